// File: rtl/icon_generator.sv
// Bot sprite pixel generator: 3-stage pipeline (window test, rotation, ROM read) plus EXTRA_DLY delay stages.
// Optional macro ICON_BLINK_EN adds a frame counter that blanks the icon while counter[BLINK_BIT] is set.
module icon_generator #(
    parameter int unsigned ICON_SIZE   = 16,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned EXTRA_DLY   = 0,
    // Sprite image, entry a (row-major) in bits [2a+1:2a]; normally generated from icon.mem
    parameter logic [2*ICON_SIZE*ICON_SIZE-1:0] ICON_IMAGE = {(ICON_SIZE*ICON_SIZE/4){8'hE4}}
`ifdef ICON_BLINK_EN
    , parameter int unsigned BLINK_BIT = 5
`endif
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [9:0] pixel_row_i,
    input  logic [9:0] pixel_column_i,
    input  logic       video_on_i,
    input  logic       frame_start_i,
    input  logic [7:0] loc_x_i,
    input  logic [7:0] loc_y_i,
    input  logic [1:0] orient_i,
    output logic [1:0] icon_px_o,
    output logic       video_on_dly_o
);

    localparam int unsigned AW = $clog2(ICON_SIZE);
    localparam int unsigned CW = 11;
    localparam logic [AW-1:0] S_MAX = AW'(ICON_SIZE - 1);

    logic [7:0]    sh_x_q, sh_y_q;
    logic [1:0]    sh_ori_q;

    logic [CW-1:0] x0_c, y0_c, u_c, v_c;
    logic [AW-1:0] s1_u_d, s1_v_d, s1_u_q, s1_v_q;
    logic          s1_hit_d, s1_hit_q, s1_von_q;
    logic [1:0]    s1_ori_q;

    logic [AW-1:0] rx_c, ry_c;
    logic [2*AW-1:0] s2_addr_d, s2_addr_q;
    logic          s2_hit_q, s2_von_q;

    logic          draw_c;
    logic [1:0]    px_d;
    logic [1:0]    px_pipe_q  [EXTRA_DLY+1];
    logic          von_pipe_q [EXTRA_DLY+1];

    // Stage 1: window test against the shadowed, scaled location; no wrap-around
    always_comb begin
        x0_c     = CW'(sh_x_q) << SCALE_SHIFT;
        y0_c     = CW'(sh_y_q) << SCALE_SHIFT;
        u_c      = CW'(pixel_column_i) - x0_c;
        v_c      = CW'(pixel_row_i) - y0_c;
        s1_hit_d = (CW'(pixel_column_i) >= x0_c) && (CW'(pixel_row_i) >= y0_c)
                   && (u_c < CW'(ICON_SIZE)) && (v_c < CW'(ICON_SIZE));
        s1_u_d   = u_c[AW-1:0];
        s1_v_d   = v_c[AW-1:0];
    end

    // Stage 2: rotate sprite coordinates by heading
    always_comb begin
        rx_c = s1_u_q;
        ry_c = s1_v_q;
        case (s1_ori_q)
            2'd1: begin rx_c = s1_v_q;         ry_c = S_MAX - s1_u_q; end
            2'd2: begin rx_c = S_MAX - s1_u_q; ry_c = S_MAX - s1_v_q; end
            2'd3: begin rx_c = S_MAX - s1_v_q; ry_c = s1_u_q;         end
            default: ;
        endcase
        s2_addr_d = {ry_c, rx_c};
    end

`ifdef ICON_BLINK_EN
    logic [5:0] frame_cnt_q;
    logic       s1_blank_q, s2_blank_q;

    // Blink state travels with the pixel so a frame boundary never splits a pixel's decision
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            frame_cnt_q <= '0;
            s1_blank_q  <= 1'b0;
            s2_blank_q  <= 1'b0;
        end else begin
            if (frame_start_i) frame_cnt_q <= frame_cnt_q + 6'd1;
            s1_blank_q <= frame_cnt_q[BLINK_BIT];
            s2_blank_q <= s1_blank_q;
        end
    end

    assign draw_c = s2_hit_q && s2_von_q && !s2_blank_q;
`else
    assign draw_c = s2_hit_q && s2_von_q;
`endif

    // Stage 3: ROM lookup, transparent outside the window or blanking
    assign px_d = draw_c ? ICON_IMAGE[{s2_addr_q, 1'b0} +: 2] : 2'b00;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sh_x_q    <= '0;
            sh_y_q    <= '0;
            sh_ori_q  <= '0;
            s1_u_q    <= '0;
            s1_v_q    <= '0;
            s1_hit_q  <= 1'b0;
            s1_von_q  <= 1'b0;
            s1_ori_q  <= '0;
            s2_addr_q <= '0;
            s2_hit_q  <= 1'b0;
            s2_von_q  <= 1'b0;
            for (int unsigned i = 0; i <= EXTRA_DLY; i++) begin
                px_pipe_q[i]  <= 2'b00;
                von_pipe_q[i] <= 1'b0;
            end
        end else begin
            if (frame_start_i) begin
                sh_x_q   <= loc_x_i;
                sh_y_q   <= loc_y_i;
                sh_ori_q <= orient_i;
            end
            s1_u_q        <= s1_u_d;
            s1_v_q        <= s1_v_d;
            s1_hit_q      <= s1_hit_d;
            s1_von_q      <= video_on_i;
            s1_ori_q      <= sh_ori_q;
            s2_addr_q     <= s2_addr_d;
            s2_hit_q      <= s1_hit_q;
            s2_von_q      <= s1_von_q;
            px_pipe_q[0]  <= px_d;
            von_pipe_q[0] <= s2_von_q;
            for (int unsigned i = 1; i <= EXTRA_DLY; i++) begin
                px_pipe_q[i]  <= px_pipe_q[i-1];
                von_pipe_q[i] <= von_pipe_q[i-1];
            end
        end
    end

    assign icon_px_o      = px_pipe_q[EXTRA_DLY];
    assign video_on_dly_o = von_pipe_q[EXTRA_DLY];

endmodule
